// File: rtl/register_file_mp.sv
// Multi-port register file with write-to-read bypass,
// optional hardwired zero register and busy scoreboard.
module register_file_mp #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 8,
  parameter int READ_PORTS = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1,
  localparam int IDX_W     = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [READ_PORTS*IDX_W-1:0]   read_index,
  output logic [READ_PORTS*WIDTH-1:0]   read_data,
  output logic [READ_PORTS-1:0]         read_busy,
  input  logic [IDX_W-1:0]              write_index,
  input  logic                          write_enable,
  input  logic [WIDTH-1:0]              write_data,
  input  logic [IDX_W-1:0]              reserve_index,
  input  logic                          reserve_enable,
  output logic                          any_busy
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [DEPTH-1:0] busy_vis;
  logic             wr_ok;
  logic             rsv_ok;

  assign wr_ok  = write_enable &&
                  !(ZERO_REG != 0 && write_index == '0);
  assign rsv_ok = reserve_enable &&
                  !(ZERO_REG != 0 && reserve_index == '0);

  // Reserve is applied after the write so it wins on a shared index
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_ok) begin
      regs_d[write_index] = write_data;
      busy_d[write_index] = 1'b0;
    end
    if (rsv_ok) begin
      busy_d[reserve_index] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        regs_q[k] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    busy_vis = busy_q;
    if (ZERO_REG != 0) begin
      busy_vis[0] = 1'b0;
    end
  end

  assign any_busy = !reset && (|busy_vis);

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    logic [IDX_W-1:0] idx;
    logic             zero_hit;
    logic             byp_hit;
    logic [WIDTH-1:0] rd;
    logic             rb;

    assign idx      = read_index[p*IDX_W +: IDX_W];
    assign zero_hit = (ZERO_REG != 0) && (idx == '0);
    assign byp_hit  = (BYPASS != 0) && write_enable &&
                      (write_index == idx);

    always_comb begin
      rd = regs_q[idx];
      rb = busy_q[idx];
      if (reset || zero_hit) begin
        rd = '0;
        rb = 1'b0;
      end else if (byp_hit) begin
        rd = write_data;
        rb = 1'b0;
      end
    end

    assign read_data[p*WIDTH +: WIDTH] = rd;
    assign read_busy[p]                = rb;
  end

endmodule
